// File: rtl/cu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, control sub-ops,
// FSM state encoding, instruction field positions and flag bit indices.
package cu_pkg;

  localparam int DATA_W  = 4;
  localparam int FLAG_W  = 5;
  localparam int INSTR_W = 12;
  localparam int REG_AW  = 2;

  // Opcodes (instr[11:8])
  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_DEC  = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_ROL  = 4'hD;
  localparam logic [3:0] OP_ROR  = 4'hE;
  localparam logic [3:0] OP_CTRL = 4'hF;

  // Control sub-ops (instr[7:6] when op == OP_CTRL)
  localparam logic [1:0] SUB_HALT = 2'b00;
  localparam logic [1:0] SUB_JMP  = 2'b01;
  localparam logic [1:0] SUB_JZ   = 2'b10;
  localparam logic [1:0] SUB_JC   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Instruction field positions
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 2;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 5;
  localparam int TGT_LSB = 0;

  // Status flag indices [P,Z,C,S,O]
  localparam int FLG_P = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_O = 0;

endpackage

// File: rtl/cu_regfile.sv
// General register file for the ALU sequencer.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all entries)
//   we_i, wa_i, wd_i  synchronous write port
//   ra_i / rd_a_o     combinational read port A
//   rb_i / rd_b_o     combinational read port B
//   dbg_sel_i / dbg_o combinational debug read port
module cu_regfile
  import cu_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rb_i,
  input  logic [REG_AW-1:0] dbg_sel_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  output logic [DATA_W-1:0] dbg_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  // Reset wins over a concurrent write, so a write pending in WB is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = mem_q[ra_i];
  assign rd_b_o = mem_q[rb_i];
  assign dbg_o  = mem_q[dbg_sel_i];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequenced control unit for the 4-bit ALU. Fetches 12-bit
// instructions from a combinational program ROM, executes LDI, ALU ops,
// JMP/JZ/JC and HALT, and writes ALU results back into a 4x4 register file.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begin execution from IDLE, or restart at 0 from HALT
//   instr / pc           ROM data / ROM address
//   alu_a, alu_b, alu_op ALU operands and opcode (non-zero only in EXEC)
//   alu_result/status    registered ALU outputs, captured in WB
//   flags                last captured ALU status [P,Z,C,S,O]
//   dbg_sel / dbg_data   combinational register-file debug read
//   busy, done           FETCH..WB / HALT indicators
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | latch instr into IR
// DECODE | execute LDI / branches / HALT, or go on to EXEC
// EXEC   | drive ALU inputs for one cycle
// WB     | write ALU result and flags, advance pc
// HALT   | done; start restarts at pc 0
module alu_sequencer
  import cu_pkg::*;
#(
  parameter int PC_W = 6,
  parameter int NREG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [FLAG_W-1:0]  alu_status,
  output logic [FLAG_W-1:0]  flags,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;

  logic                rf_we;
  logic [DATA_W-1:0]   rf_wd;
  logic [DATA_W-1:0]   rf_a, rf_b;

  logic [3:0]          ir_op;
  logic [1:0]          ir_sub;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     pc_tgt;

  assign ir_op  = ir_q[OP_MSB:OP_LSB];
  assign ir_sub = ir_q[RD_MSB:RD_LSB];
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = PC_W'(ir_q[TGT_MSB:TGT_LSB]);

  cu_regfile #(.NREG(NREG)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .wa_i      (ir_q[RD_MSB:RD_LSB]),
    .wd_i      (rf_wd),
    .ra_i      (ir_q[RA_MSB:RA_LSB]),
    .rb_i      (ir_q[RB_MSB:RB_LSB]),
    .dbg_sel_i (dbg_sel),
    .rd_a_o    (rf_a),
    .rd_b_o    (rf_b),
    .dbg_o     (dbg_data)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (ir_op == OP_LDI) begin
          state_d = ST_FETCH;
        end else if (ir_op == OP_CTRL) begin
          state_d = (ir_sub == SUB_HALT) ? ST_HALT : ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   if (start) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; branch conditions use flags from before this instr
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    rf_we   = 1'b0;
    rf_wd   = '0;
    case (state_q)
      ST_FETCH: ir_d = instr;
      ST_DECODE: begin
        if (ir_op == OP_LDI) begin
          rf_we = 1'b1;
          rf_wd = ir_q[IMM_MSB:IMM_LSB];
          pc_d  = pc_inc;
        end else if (ir_op == OP_CTRL) begin
          case (ir_sub)
            SUB_JMP: pc_d = pc_tgt;
            SUB_JZ:  pc_d = flags_q[FLG_Z] ? pc_tgt : pc_inc;
            SUB_JC:  pc_d = flags_q[FLG_C] ? pc_tgt : pc_inc;
            default: pc_d = pc_q;
          endcase
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        rf_wd   = alu_result;
        flags_d = alu_status;
        pc_d    = pc_inc;
      end
      ST_HALT: if (start) pc_d = '0;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      ST_FETCH, ST_DECODE, ST_WB: busy = 1'b1;
      ST_EXEC: begin
        busy   = 1'b1;
        alu_op = ir_op;
        alu_a  = rf_a;
        alu_b  = rf_b;
      end
      ST_HALT: done = 1'b1;
      default: ;
    endcase
  end

  assign pc    = pc_q;
  assign flags = flags_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Micro-sequenced control unit for the 4-bit ALU: fetches 12-bit instructions from an external program ROM, decodes them, and drives the ALU operand and opcode inputs.
- Waits out the ALU's one-cycle registered latency, writes results into a 4x4-bit register file and latches the 5-bit status flags [P,Z,C,S,O].
- Provides immediate load, unconditional jump, flag-conditional branches and halt.
- Sits between program memory and the ALU; it is the top-level controller of the datapath.

Parameters:
- PC_W, 6, program counter / ROM address width (program depth 2^PC_W).
- NREG, 4, number of general registers (fixed at 4; rd/ra/rb fields are 2 bits).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  level/pulse; begins execution from IDLE or HALT
- instr  in  12  ROM data at address pc (combinational ROM, valid same cycle)
- pc  out  PC_W  ROM address / program counter
- alu_a  out  4  ALU operand A
- alu_b  out  4  ALU operand B
- alu_op  out  4  ALU opcode
- alu_result  in  4  registered ALU result
- alu_status  in  5  registered ALU flags [P,Z,C,S,O]
- flags  out  5  last captured ALU status
- dbg_sel  in  2  register-file debug read select
- dbg_data  out  4  register contents at dbg_sel (combinational)
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- done  out  1  high while in HALT

Behaviour:
- Instruction format: [11:8] op, [7:6] rd, [5:4] ra, [3:2] rb, [3:0] imm4, [5:0] target (low PC_W bits).
- op 0000 = LDI: rd <= imm4.
- op 0001..1110 = ALU ops: rd <= ALU(op, R[ra], R[rb]).
- op 1111 = control, subop [7:6]:
  - 00 HALT
  - 01 JMP target
  - 10 JZ target (taken if flags[3]=1)
  - 11 JC target (taken if flags[2]=1)
- Reset values: state IDLE, pc=0, all registers 0, flags=0, IR=0, alu_a=alu_b=alu_op=0, busy=0, done=0.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: start=1 -> FETCH.
  - FETCH: IR <= instr -> DECODE.
  - DECODE, LDI: write rd, pc <= pc+1 -> FETCH.
  - DECODE, ALU op: -> EXEC.
  - DECODE, branch: pc <= taken ? target : pc+1 -> FETCH. Condition uses flags as latched before this instruction.
  - DECODE, HALT: pc unchanged -> HALT.
  - EXEC: alu_op=IR[11:8], alu_a=R[ra], alu_b=R[rb] held for this one cycle; ALU registers at the end of EXEC -> WB.
  - WB: R[rd] <= alu_result, flags <= alu_status, pc <= pc+1 -> FETCH.
  - HALT: done=1. start=1 -> pc <= 0, -> FETCH; registers and flags are preserved.
- alu_op/alu_a/alu_b are 0 in every state except EXEC.
- flags change only in WB; LDI and branches never modify flags.
- Cycle counts: ALU instruction 4, LDI 2, branch 2, HALT 2 to reach HALT.
- pc+1 wraps modulo 2^PC_W (last address -> 0).
- start is ignored while busy=1.
- rd equal to ra or rb is legal: reads occur in EXEC, write in WB.
- rst has priority over everything. Reset asserted in any state, including mid-EXEC, yields reset values on the next cycle. A write pending in WB is discarded.

Decomposition:
- Shared package cu_pkg holds:
  - opcode constants OP_LDI, OP_ADD..OP_ROR, OP_CTRL
  - control subop constants SUB_HALT, SUB_JMP, SUB_JZ, SUB_JC
  - state enum
  - instruction field bit positions
  - flag index constants FLG_P=4, FLG_Z=3, FLG_C=2, FLG_S=1, FLG_O=0
- Sub-module cu_regfile: 4x4-bit storage, 2 combinational read ports plus debug read port, 1 synchronous write port, synchronous reset to 0.

Test Plan:
- Program LDI r0,5; LDI r1,3; ADD r2,r0,r1 (0x184); HALT, then pulse start -> r2=8 via dbg_data. flags Z=0, C=0. done rises 10 cycles after FETCH entry. pc=3.
- LDI r0,9; LDI r1,9; ADD r2,r0,r1; JC 0x3F; at 0x3F LDI r3,1; then wrap -> r2=2, flags[2]=1, jump taken. After r3=1, pc wraps 0x3F -> 0x00.
- SUB r0,r0,r0 after r0=6; JZ 10 -> flags[3]=1, pc=10. Repeat with flags Z=0 -> pc increments.
- Assert rst during EXEC of an ADD -> next cycle IDLE: pc=0, alu_op=0, regs 0, busy=0, and rd is not written.
- start pulse while busy -> no effect on pc or state. start in HALT -> pc=0, FETCH, register values retained.
- Check every EXEC cycle: alu_op equals IR[11:8] and is 0 in all other states. An LDI never alters flags.
